// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the writeback request record for the regfile
// writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-input round-robin arbiter.
// The pointer names the requester with highest priority next.
// It advances past the winner on each accept.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int               j;
            logic [IDX_W-1:0] jj;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found     = 1'b1;
                grant[jj] = 1'b1;
                grant_idx = jj;
            end
        end
    end

    // Wrap modulo N, which need not be a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N_REQ writeback requesters.
// It also tracks a per-register busy scoreboard for the issue stage.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
    localparam int NREGS = 2 ** ADDR_W,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_rd,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_rd,
    output logic [NREGS-1:0]        busy,
    output logic                    regf_write_CS,
    output logic [ADDR_W-1:0]       rd_add,
    output logic [DATA_W-1:0]       write_data
);

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              xfer;
    logic [ADDR_W-1:0] g_rd;
    logic [DATA_W-1:0] g_data;
    logic [NREGS-1:0]  busy_nxt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .accept    (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = reset ? '0 : grant;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        g_rd   = '0;
        g_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                g_rd   = req_rd[i*ADDR_W +: ADDR_W];
                g_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write to x0 is accepted from the requester but never reaches the regfile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regf_write_CS <= 1'b0;
            rd_add        <= '0;
            write_data    <= '0;
        end else if (xfer) begin
            regf_write_CS <= (g_rd != ADDR_W'(REG_ZERO));
            rd_add        <= g_rd;
            write_data    <= g_data;
        end else begin
            regf_write_CS <= 1'b0;
        end
    end

    // Set after clear so a new reservation outlives the retiring write.
    always_comb begin
        busy_nxt = busy;
        if (regf_write_CS)
            busy_nxt[rd_add] = 1'b0;
        if (rsv_valid && rsv_rd != ADDR_W'(REG_ZERO))
            busy_nxt[rsv_rd] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter.
// A cycle-level reference model follows the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NR = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_rd;
    logic [N*DW-1:0]   req_data;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_rd;
    logic [NR-1:0]     busy;
    logic              regf_write_CS;
    logic [AW-1:0]     rd_add;
    logic [DW-1:0]     write_data;

    wb_req_t rq [N];

    always_comb begin
        req_rd   = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_rd[i*AW +: AW]   = rq[i].rd;
            req_data[i*DW +: DW] = rq[i].data;
        end
    end

    regfile_wb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .rsv_valid     (rsv_valid),
        .rsv_rd        (rsv_rd),
        .busy          (busy),
        .regf_write_CS (regf_write_CS),
        .rd_add        (rd_add),
        .write_data    (write_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: next-priority requester, registered write, busy bits.
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    logic [NR-1:0] m_busy;
    int            last_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_busy = '0;
        last_g = -1;
    endtask

    // One clock: check at the falling edge, advance model at the rising edge.
    task automatic step();
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [NR-1:0] nb;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", 64'(req_ready), 64'(exp_rdy));
        chk("we", 64'(regf_write_CS), 64'(m_we));
        chk("rd_add", 64'(rd_add), 64'(m_rd));
        chk("wdata", 64'(write_data), 64'(m_data));
        chk("busy", 64'(busy), 64'(m_busy));
        @(posedge clk);
        nb = m_busy;
        if (m_we) nb[m_rd] = 1'b0;
        if (rsv_valid && rsv_rd != 0) nb[rsv_rd] = 1'b1;
        nb[0] = 1'b0;
        m_busy = nb;
        if (g >= 0) begin
            m_ptr  = (g + 1) % N;
            m_we   = (rq[g].rd != 0);
            m_rd   = rq[g].rd;
            m_data = rq[g].data;
        end else begin
            m_we = 1'b0;
        end
        last_g = g;
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i] = v;
        rq[i].rd     = rd;
        rq[i].data   = d;
    endtask

    task automatic rand_drive();
        for (int i = 0; i < N; i++) begin
            if (last_g == i || !req_valid[i]) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rq[i].rd     = AW'($urandom_range(0, NR - 1));
                rq[i].data   = DW'($urandom);
            end
        end
        rsv_valid = ($urandom_range(0, 2) == 0);
        rsv_rd    = AW'($urandom_range(0, NR - 1));
    endtask

    initial begin
        logic [AW-1:0] prev;
        reset     = 1'b1;
        req_valid = '0;
        rsv_valid = 1'b0;
        rsv_rd    = '0;
        for (int i = 0; i < N; i++) rq[i] = '0;
        model_reset();
        #1;
        req_valid = 2'b01;
        #2;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(regf_write_CS), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd", 64'(rd_add), 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single requester
        set_req(0, 1'b1, 4'd5, 32'hDEADBEEF);
        step();
        req_valid = '0;
        chk("single_we", 64'(regf_write_CS), 64'd1);
        chk("single_rd", 64'(rd_add), 64'd5);
        chk("single_data", 64'(write_data), 64'hDEADBEEF);
        step();
        chk("single_idle", 64'(regf_write_CS), 64'd0);

        // Contention: writes alternate with no idle cycle
        set_req(0, 1'b1, 4'd1, 32'h11);
        set_req(1, 1'b1, 4'd2, 32'h22);
        step();
        prev = rd_add;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("alt_we", 64'(regf_write_CS), 64'd1);
            chk("alt_rd", 64'(rd_add), (prev == 4'd1) ? 64'd2 : 64'd1);
            prev = rd_add;
        end
        req_valid = '0;
        step();

        // x0 write accepted and dropped
        set_req(1, 1'b1, 4'd0, 32'hFFFFFFFF);
        step();
        req_valid = '0;
        chk("x0_xfer", 64'(last_g), 64'd1);
        chk("x0_we", 64'(regf_write_CS), 64'd0);
        chk("x0_busy0", 64'(busy[0]), 64'd0);
        step();

        // Scoreboard reserve then retire
        rsv_valid = 1'b1;
        rsv_rd    = 4'd7;
        step();
        rsv_valid = 1'b0;
        chk("sb_set", 64'(busy[7]), 64'd1);
        set_req(0, 1'b1, 4'd7, 32'h77);
        step();
        req_valid = '0;
        chk("sb_pending", 64'(busy[7]), 64'd1);
        step();
        chk("sb_clr", 64'(busy[7]), 64'd0);

        // Set wins over simultaneous clear
        rsv_valid = 1'b1;
        rsv_rd    = 4'd3;
        step();
        rsv_valid = 1'b0;
        set_req(0, 1'b1, 4'd3, 32'h33);
        step();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_rd    = 4'd3;
        step();
        rsv_valid = 1'b0;
        chk("sb_collide", 64'(busy[3]), 64'd1);
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rand_drive();
            step();
        end

        // Reset in the middle of a transfer
        rsv_valid = 1'b1;
        rsv_rd    = 4'd9;
        set_req(0, 1'b1, 4'd9, 32'h99);
        req_valid[1] = 1'b0;
        step();
        rsv_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 64'(regf_write_CS), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 2'b11;
        rq[1].rd  = 4'd4;
        step();
        chk("post_rst_first", 64'(last_g), 64'd0);
        req_valid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
